// File: rtl/dh_link_pkg.sv
// Shared types for the drone/CC link arbiter: FSM states, grant encodings
// and the round-robin pick between the two drone request latches.
package dh_link_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_CC = 2'd2,
    DELIVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_D1   = 2'b01,
    GNT_D2   = 2'b10
  } gnt_t;

  // On a tie the drone that did not own the channel last time wins.
  function automatic gnt_t rr_pick(input logic p1, input logic p2, input gnt_t last);
    gnt_t pick;
    pick = GNT_NONE;
    if (p1 && p2) begin
      if (last == GNT_D1) pick = GNT_D2;
      else                pick = GNT_D1;
    end else if (p1) begin
      pick = GNT_D1;
    end else if (p2) begin
      pick = GNT_D2;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dh_link_arbiter_if.sv
// Drone-side and CC-side message bus of the link arbiter.
// slave: the arbiter's view; master: the view of whatever drives the drones and CC.
interface dh_link_arbiter_if #(parameter int N = 8);
  logic           mess_rdy_d1;
  logic [2*N-1:0] mess_d1;
  logic           mess_rdy_d2;
  logic [2*N-1:0] mess_d2;
  logic [N-1:0]   mess_input_d1;
  logic           received_d1;
  logic [N-1:0]   mess_input_d2;
  logic           received_d2;
  logic           drone_rdy;
  logic [2*N-1:0] mess_input_cc;
  logic [N-1:0]   mess_out_cc;
  logic           cc_rdy;
  logic [1:0]     grant;
  logic           timeout_err;
  logic           overrun_err;

  modport slave (
    input  mess_rdy_d1, mess_d1, mess_rdy_d2, mess_d2, mess_out_cc, cc_rdy,
    output mess_input_d1, received_d1, mess_input_d2, received_d2,
           drone_rdy, mess_input_cc, grant, timeout_err, overrun_err
  );

  modport master (
    output mess_rdy_d1, mess_d1, mess_rdy_d2, mess_d2, mess_out_cc, cc_rdy,
    input  mess_input_d1, received_d1, mess_input_d2, received_d2,
           drone_rdy, mess_input_cc, grant, timeout_err, overrun_err
  );
endinterface

// File: rtl/dh_req_latch.sv
// One-deep request holder for a single drone: pend flag, message register, overrun detect.
// Request strobe at an edge is visible on o_pend/o_msg after that edge; o_ovr is combinational.
module dh_req_latch #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ena,
  input  logic         i_req_vld,
  input  logic [W-1:0] i_req_dat,
  input  logic         i_clr,
  output logic         o_pend,
  output logic [W-1:0] o_msg,
  output logic         o_ovr
);

  logic         r_pend;
  logic [W-1:0] r_msg;

  // A request arriving on the same edge this one is granted is a fresh request.
  assign o_ovr  = i_req_vld & r_pend & ~i_clr;
  assign o_pend = r_pend;
  assign o_msg  = r_msg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_msg  <= '0;
    end else if (i_ena) begin
      if (i_req_vld) begin
        r_pend <= 1'b1;
        r_msg  <= i_req_dat;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dh_link_arbiter.sv
// Registered round-robin arbiter linking two drone key-exchange engines to one CC engine.
// Request to drone_rdy: 2 edges; cc_rdy to received: 1 edge; WAIT_CC aborts after TIMEOUT cycles.
module dh_link_arbiter
  import dh_link_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  input logic           ena,
  dh_link_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT);

  state_t         r_state;
  gnt_t           r_grant;
  gnt_t           r_last;
  logic           r_drone_rdy;
  logic           r_rcv1;
  logic           r_rcv2;
  logic           r_tout;
  logic           r_ovr;
  logic [2*N-1:0] r_cc_msg;
  logic [N-1:0]   r_rep1;
  logic [N-1:0]   r_rep2;
  logic [CW-1:0]  r_cnt;

  logic           w_pend1;
  logic           w_pend2;
  logic           w_ovr1;
  logic           w_ovr2;
  logic [2*N-1:0] w_msg1;
  logic [2*N-1:0] w_msg2;
  gnt_t           w_pick;
  logic           w_clr1;
  logic           w_clr2;

  assign w_pick = (r_state == IDLE) ? rr_pick(w_pend1, w_pend2, r_last) : GNT_NONE;
  assign w_clr1 = (w_pick == GNT_D1);
  assign w_clr2 = (w_pick == GNT_D2);

  dh_req_latch #(.W(2*N)) u_req_d1 (
    .clk       (clk),
    .rst       (rst),
    .i_ena     (ena),
    .i_req_vld (bus.mess_rdy_d1),
    .i_req_dat (bus.mess_d1),
    .i_clr     (w_clr1),
    .o_pend    (w_pend1),
    .o_msg     (w_msg1),
    .o_ovr     (w_ovr1)
  );

  dh_req_latch #(.W(2*N)) u_req_d2 (
    .clk       (clk),
    .rst       (rst),
    .i_ena     (ena),
    .i_req_vld (bus.mess_rdy_d2),
    .i_req_dat (bus.mess_d2),
    .i_clr     (w_clr2),
    .o_pend    (w_pend2),
    .o_msg     (w_msg2),
    .o_ovr     (w_ovr2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= GNT_NONE;
      r_last      <= GNT_D2;
      r_drone_rdy <= 1'b0;
      r_rcv1      <= 1'b0;
      r_rcv2      <= 1'b0;
      r_tout      <= 1'b0;
      r_ovr       <= 1'b0;
      r_cc_msg    <= '0;
      r_rep1      <= '0;
      r_rep2      <= '0;
      r_cnt       <= '0;
    end else if (ena) begin
      r_tout <= 1'b0;
      r_ovr  <= w_ovr1 | w_ovr2;
      case (r_state)
        IDLE: begin
          if (w_pick != GNT_NONE) begin
            r_grant     <= w_pick;
            r_last      <= w_pick;
            r_drone_rdy <= 1'b1;
            r_cc_msg    <= (w_pick == GNT_D1) ? w_msg1 : w_msg2;
            r_state     <= SEND;
          end
        end
        SEND: begin
          r_drone_rdy <= 1'b0;
          r_cnt       <= '0;
          r_state     <= WAIT_CC;
        end
        WAIT_CC: begin
          // A reply on the final count still completes the transaction.
          if (bus.cc_rdy) begin
            if (r_grant == GNT_D1) begin
              r_rep1 <= bus.mess_out_cc;
              r_rcv1 <= 1'b1;
            end else begin
              r_rep2 <= bus.mess_out_cc;
              r_rcv2 <= 1'b1;
            end
            r_state <= DELIVER;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_tout  <= 1'b1;
            r_grant <= GNT_NONE;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DELIVER: begin
          r_rcv1   <= 1'b0;
          r_rcv2   <= 1'b0;
          r_rep1   <= '0;
          r_rep2   <= '0;
          r_grant  <= GNT_NONE;
          r_cc_msg <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mess_input_d1 = r_rep1;
  assign bus.received_d1   = r_rcv1;
  assign bus.mess_input_d2 = r_rep2;
  assign bus.received_d2   = r_rcv2;
  assign bus.drone_rdy     = r_drone_rdy;
  assign bus.mess_input_cc = r_cc_msg;
  assign bus.grant         = r_grant;
  assign bus.timeout_err   = r_tout;
  assign bus.overrun_err   = r_ovr;

endmodule
